cpu_clk_ctrl: RTL and testbench

//  Clock-enable generator that sits directly upstream of openmips_min_sopc and the 7-seg scanner.
//  In RUN mode it issues a CPU tick every CPU_DIV clocks. In STEP mode it issues exactly one

---
 rtl/cpu_clk_ctrl_pkg.sv | 19 +
 rtl/cpu_clk_ctrl_if.sv | 29 ++
 rtl/cpu_clk_ctrl_debounce.sv | 52 +++++
 rtl/cpu_clk_ctrl.sv | 155 +++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_clk_ctrl_pkg.sv
// cpu_clk_pkg: shared definitions for the CPU clock-enable controller.
//   - cpu_state_t : FSM state encoding used by cpu_clk_ctrl
//   - *_DEF       : default divider/debounce constants for the board build
//   - STEP_W      : width of the issued-tick debug counter
package cpu_clk_pkg;

   typedef enum logic [1:0] {
      PAUSE = 2'd0,
      RUN   = 2'd1,
      HOLD  = 2'd2
   } cpu_state_t;

   localparam int unsigned CPU_DIV_DEF    = 50_000_000;
   localparam int unsigned SCAN_DIV_DEF   = 100_000;
   localparam int unsigned DEB_CYCLES_DEF = 1_000_000;
   localparam int unsigned CNT_W_DEF      = 32;
   localparam int unsigned STEP_W         = 16;

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// cpu_clk_ctrl_if: board-side signal bundle of the CPU clock-enable controller.
//   mode_run  : slide switch, 1 = RUN, 0 = STEP (asynchronous)
//   btn_step  : bouncing push-button, 1 = pressed (asynchronous)
//   cpu_ce    : one-cycle CPU tick
//   scan_ce   : one-cycle display scan tick
//   running   : FSM is in RUN
//   step_cnt  : number of CPU ticks issued since reset
// master = board/stimulus side, slave = controller side.
interface cpu_clk_ctrl_if;
   import cpu_clk_pkg::*;

   logic              mode_run;
   logic              btn_step;
   logic              cpu_ce;
   logic              scan_ce;
   logic              running;
   logic [STEP_W-1:0] step_cnt;

   modport master (
      output mode_run, btn_step,
      input  cpu_ce, scan_ce, running, step_cnt
   );

   modport slave (
      input  mode_run, btn_step,
      output cpu_ce, scan_ce, running, step_cnt
   );

endinterface

// File: rtl/cpu_clk_ctrl_debounce.sv
// btn_debounce: 2-FF synchroniser plus level debouncer for a push-button.
//   clk       : board clock
//   rst       : asynchronous active-low reset
//   btn_async : raw button, 1 = pressed
//   level     : accepted (debounced) button level
//   press_p   : one-cycle pulse on an accepted 0->1 change
// A new level is accepted once the synchronised input has disagreed with the
// accepted level for DEB_CYCLES consecutive cycles; any agreement in between
// restarts the count.
module btn_debounce #(
   parameter int unsigned DEB_CYCLES = 1_000_000,
   parameter int unsigned CNT_W      = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_async,
   output logic level,
   output logic press_p
);

   localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             btn_s1;
   logic             btn_s2;
   logic [CNT_W-1:0] stab_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_s1   <= 1'b0;
         btn_s2   <= 1'b0;
         stab_cnt <= '0;
         level    <= 1'b0;
         press_p  <= 1'b0;
      end else begin
         btn_s1  <= btn_async;
         btn_s2  <= btn_s1;
         press_p <= 1'b0;
         if (btn_s2 != level) begin
            if (stab_cnt == STAB_LAST) begin
               level    <= btn_s2;
               press_p  <= btn_s2;
               stab_cnt <= '0;
            end else begin
               stab_cnt <= stab_cnt + CNT_W'(1);
            end
         end else begin
            stab_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: clock-enable generator for the soft CPU and 7-seg scanner.
//   clk : board clock (only domain)
//   rst : asynchronous active-low reset
//   bus : cpu_clk_ctrl_if.slave (mode_run, btn_step in; cpu_ce, scan_ce,
//         running, step_cnt out)
// RUN issues a tick every CPU_DIV clocks; STEP issues one tick per debounced
// press. scan_ce free-runs every SCAN_DIV clocks regardless of mode.
//
// state | meaning
// PAUSE | idle in STEP mode, waiting for a press or for RUN mode
// RUN   | free-running divider, tick every CPU_DIV clocks
// HOLD  | tick issued for a press, waiting for the button release
module cpu_clk_ctrl
   import cpu_clk_pkg::*;
#(
   parameter int unsigned CPU_DIV    = CPU_DIV_DEF,
   parameter int unsigned SCAN_DIV   = SCAN_DIV_DEF,
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input logic           clk,
   input logic           rst,
   cpu_clk_ctrl_if.slave bus
);

   if (CPU_DIV < 2) begin : g_bad_cpu_div
      $error("cpu_clk_ctrl: CPU_DIV must be >= 2");
   end
   if (SCAN_DIV < 2) begin : g_bad_scan_div
      $error("cpu_clk_ctrl: SCAN_DIV must be >= 2");
   end
   if (DEB_CYCLES < 1) begin : g_bad_deb
      $error("cpu_clk_ctrl: DEB_CYCLES must be >= 1");
   end

   localparam logic [CNT_W-1:0] CPU_LAST  = CNT_W'(CPU_DIV - 1);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

   logic              mode_s1;
   logic              mode_s2;
   logic              btn_level;
   logic              press_p;
   logic [CNT_W-1:0]  scan_cnt;
   logic              scan_ce_q;
   cpu_state_t        state;
   cpu_state_t        state_nxt;
   logic [CNT_W-1:0]  cpu_cnt;
   logic [CNT_W-1:0]  cpu_cnt_nxt;
   logic              cpu_ce_nxt;
   logic              cpu_ce_q;
   logic              running_q;
   logic [STEP_W-1:0] step_cnt_q;

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
   ) u_btn_debounce (
      .clk       (clk),
      .rst       (rst),
      .btn_async (bus.btn_step),
      .level     (btn_level),
      .press_p   (press_p)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_s1 <= 1'b0;
         mode_s2 <= 1'b0;
      end else begin
         mode_s1 <= bus.mode_run;
         mode_s2 <= mode_s1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt  <= '0;
         scan_ce_q <= 1'b0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt  <= '0;
         scan_ce_q <= 1'b1;
      end else begin
         scan_cnt  <= scan_cnt + CNT_W'(1);
         scan_ce_q <= 1'b0;
      end
   end

   // Mode has priority over a coincident press in PAUSE, and a mode drop in
   // RUN wins over a terminal count so no partial tick escapes.
   always_comb begin
      state_nxt   = state;
      cpu_cnt_nxt = cpu_cnt;
      cpu_ce_nxt  = 1'b0;
      case (state)
         PAUSE: begin
            if (mode_s2) begin
               state_nxt   = RUN;
               cpu_cnt_nxt = '0;
            end else if (press_p) begin
               state_nxt  = HOLD;
               cpu_ce_nxt = 1'b1;
            end
         end
         RUN: begin
            if (!mode_s2) begin
               state_nxt   = PAUSE;
               cpu_cnt_nxt = '0;
            end else if (cpu_cnt == CPU_LAST) begin
               cpu_cnt_nxt = '0;
               cpu_ce_nxt  = 1'b1;
            end else begin
               cpu_cnt_nxt = cpu_cnt + CNT_W'(1);
            end
         end
         HOLD: begin
            if (!btn_level) begin
               state_nxt = PAUSE;
            end
         end
         default: begin
            state_nxt   = PAUSE;
            cpu_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= PAUSE;
         cpu_cnt   <= '0;
         cpu_ce_q  <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         cpu_cnt   <= cpu_cnt_nxt;
         cpu_ce_q  <= cpu_ce_nxt;
         running_q <= (state_nxt == RUN);
      end
   end

   // Only written when a tick is issued, so the counter holds otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step_cnt_q <= '0;
      end else if (cpu_ce_nxt) begin
         step_cnt_q <= step_cnt_q + STEP_W'(1);
      end
   end

   assign bus.cpu_ce   = cpu_ce_q;
   assign bus.scan_ce  = scan_ce_q;
   assign bus.running  = running_q;
   assign bus.step_cnt = step_cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl with CPU_DIV=4, SCAN_DIV=3, DEB_CYCLES=5.
// A cycle-level behavioural model is compared against the DUT every cycle;
// directed sections pin the model with hand-computed literal expectations,
// then a randomized section exercises mode, button and reset interaction.
module tb_cpu_clk_ctrl;

   localparam int CPU_DIV  = 4;
   localparam int SCAN_DIV = 3;
   localparam int DEB      = 5;

   localparam int M_IDLE = 0;
   localparam int M_FREE = 1;
   localparam int M_HELD = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cpu_clk_ctrl_if bus ();

   cpu_clk_ctrl #(
      .CPU_DIV    (CPU_DIV),
      .SCAN_DIV   (SCAN_DIV),
      .DEB_CYCLES (DEB),
      .CNT_W      (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int m_mode_d1, m_mode_d2, m_btn_d1, m_btn_d2;
   int m_acc, m_disagree, m_press;
   int m_cyc, m_phase, m_age;
   int m_cpu_ce, m_scan_ce, m_running, m_step;
   int preset_seq = 0;
   int preset_seen = 0;

   task automatic model_step();
      int tick;
      int new_press;
      if (!rst) begin
         m_mode_d1 = 0; m_mode_d2 = 0; m_btn_d1 = 0; m_btn_d2 = 0;
         m_acc = 0; m_disagree = 0; m_press = 0;
         m_cyc = 0; m_phase = M_IDLE; m_age = 0;
         m_cpu_ce = 0; m_scan_ce = 0; m_running = 0; m_step = 0;
         preset_seen = preset_seq;
         return;
      end
      tick = 0;
      // mode/press decisions use what was visible during the ending cycle
      if (m_phase == M_IDLE) begin
         if (m_mode_d2 == 1) begin
            m_phase = M_FREE; m_age = 0;
         end else if (m_press == 1) begin
            m_phase = M_HELD; tick = 1;
         end
      end else if (m_phase == M_FREE) begin
         if (m_mode_d2 == 0) m_phase = M_IDLE;
         else begin
            m_age++;
            if (m_age % CPU_DIV == 0) tick = 1;
         end
      end else begin
         if (m_acc == 0) m_phase = M_IDLE;
      end
      // debouncer: a level needs DEB consecutive cycles of disagreement
      new_press = 0;
      if (m_btn_d2 != m_acc) begin
         m_disagree++;
         if (m_disagree == DEB) begin
            m_acc = m_btn_d2; new_press = m_btn_d2; m_disagree = 0;
         end
      end else m_disagree = 0;
      m_press = new_press;
      m_btn_d2 = m_btn_d1; m_btn_d1 = int'(bus.btn_step);
      m_mode_d2 = m_mode_d1; m_mode_d1 = int'(bus.mode_run);
      m_cyc++;
      m_scan_ce = (m_cyc % SCAN_DIV == 0) ? 1 : 0;
      if (preset_seq != preset_seen) begin
         m_step = 16'hFFFF; preset_seen = preset_seq;
      end
      if (tick == 1) m_step = (m_step + 1) & 16'hFFFF;
      m_cpu_ce  = tick;
      m_running = (m_phase == M_FREE) ? 1 : 0;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         check("model cpu_ce",   int'(bus.cpu_ce),   m_cpu_ce);
         check("model scan_ce",  int'(bus.scan_ce),  m_scan_ce);
         check("model running",  int'(bus.running),  m_running);
         check("model step_cnt", int'(bus.step_cnt), m_step);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus + literal expectations ----------------
   task automatic window(input int len, output int n_ce, output int first_at);
      n_ce = 0; first_at = 0;
      for (int j = 1; j <= len; j++) begin
         @(posedge clk); #1;
         if (bus.cpu_ce) begin
            n_ce++;
            if (first_at == 0) first_at = j;
         end
      end
   endtask

   initial begin
      int pulses, k, n_ce, at;
      bus.mode_run = 1'b1;
      bus.btn_step = 1'b0;
      rst = 1'b0;

      // 1. reset held with mode_run=1
      repeat (3) @(posedge clk);
      #1;
      check("rst cpu_ce",   int'(bus.cpu_ce),   0);
      check("rst scan_ce",  int'(bus.scan_ce),  0);
      check("rst running",  int'(bus.running),  0);
      check("rst step_cnt", int'(bus.step_cnt), 0);
      @(negedge clk); rst = 1'b1;

      // 1/2. scan ticks at 3,6,9,12; running at 3; cpu ticks at 7,11
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         check($sformatf("scan_ce@%0d", c), int'(bus.scan_ce), (c % 3 == 0) ? 1 : 0);
         check($sformatf("cpu_ce@%0d", c), int'(bus.cpu_ce), (c == 7 || c == 11) ? 1 : 0);
         if (c == 2) check("running@2", int'(bus.running), 0);
         if (c == 3) check("running@3", int'(bus.running), 1);
      end
      pulses = 2; k = 12;
      while (pulses < 10 && k < 100) begin
         @(posedge clk); #1; k++;
         if (bus.cpu_ce) begin
            pulses++;
            check("run tick spacing", k, 3 + 4 * pulses);
         end
      end
      check("run pulses", pulses, 10);
      check("run step_cnt", int'(bus.step_cnt), 10);

      // 4. mode drop reaching the synchroniser as cpu_cnt becomes 2
      @(posedge clk);
      @(negedge clk); bus.mode_run = 1'b0;
      for (int j = 2; j <= 8; j++) begin
         @(posedge clk); #1;
         check($sformatf("drop cpu_ce+%0d", j), int'(bus.cpu_ce), 0);
         if (j == 3) check("drop running+3", int'(bus.running), 1);
         if (j == 4) check("drop running+4", int'(bus.running), 0);
      end

      // 3. STEP with a 3-cycle bounce, from a fresh reset
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      repeat (4) @(negedge clk);
      bus.btn_step = 1'b1;
      @(negedge clk); bus.btn_step = 1'b0;
      @(negedge clk); bus.btn_step = 1'b1;
      window(20, n_ce, at);
      check("step ticks", n_ce, 1);
      check("step latency", at, 8);
      check("step step_cnt", int'(bus.step_cnt), 1);
      @(negedge clk); bus.btn_step = 1'b0;
      repeat (3) @(negedge clk);
      bus.btn_step = 1'b1;
      window(20, n_ce, at);
      check("short release ticks", n_ce, 0);
      @(negedge clk); bus.btn_step = 1'b0;
      repeat (10) @(negedge clk);
      bus.btn_step = 1'b1;
      window(20, n_ce, at);
      check("second press ticks", n_ce, 1);
      check("second press step_cnt", int'(bus.step_cnt), 2);

      // 5. wrap of step_cnt, then reset while in HOLD
      @(negedge clk); bus.btn_step = 1'b0;
      repeat (10) @(negedge clk);
      force dut.step_cnt_q = 16'hFFFF;
      preset_seq++;
      #1 release dut.step_cnt_q;
      #1 check("preset step_cnt", int'(bus.step_cnt), 16'hFFFF);
      @(negedge clk); bus.btn_step = 1'b1;
      window(20, n_ce, at);
      check("wrap ticks", n_ce, 1);
      check("wrap step_cnt", int'(bus.step_cnt), 0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      window(20, n_ce, at);
      check("hold-reset ticks", n_ce, 1);
      check("hold-reset latency", at, 8);
      check("hold-reset step_cnt", int'(bus.step_cnt), 1);

      // randomized mode/button/reset activity against the model
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 599) != 0);
         if ($urandom_range(0, 39) == 0) bus.mode_run = ~bus.mode_run;
         if ($urandom_range(0, 5) == 0)  bus.btn_step = ~bus.btn_step;
      end
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
